// File: rtl/result_hilo_stage_if.sv
// Issue/result bundle between the execute datapath and the HI/LO result stage.
interface result_hilo_stage_if #(
  parameter int unsigned CW = 6
);
  logic [CW-1:0] Signal;
  logic          inValid;
  logic [31:0]   ALUOut;
  logic [31:0]   ShifterOut;
  logic [63:0]   MulProduct;
  logic          MulDone;
  logic [31:0]   dataOut;
  logic          outValid;
  logic          ready;
  logic          errOp;

  modport master (
    output Signal, inValid, ALUOut, ShifterOut, MulProduct, MulDone,
    input  dataOut, outValid, ready, errOp
  );

  modport slave (
    input  Signal, inValid, ALUOut, ShifterOut, MulProduct, MulDone,
    output dataOut, outValid, ready, errOp
  );
endinterface

// File: rtl/result_hilo_stage.sv
// Result select stage: routes ALU/shifter results, holds HI/LO and waits on the
// multiplier for MULTU with a bounded timeout.
module result_hilo_stage #(
  parameter int unsigned MUL_TIMEOUT = 40,
  parameter int unsigned CW          = 6
) (
  input  logic               clk,
  input  logic               reset,
  result_hilo_stage_if.slave bus
);

  localparam int unsigned CNT_W = (MUL_TIMEOUT > 2) ? $clog2(MUL_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

  localparam logic [CW-1:0] FN_AND   = CW'(36);
  localparam logic [CW-1:0] FN_OR    = CW'(37);
  localparam logic [CW-1:0] FN_ADD   = CW'(32);
  localparam logic [CW-1:0] FN_SUB   = CW'(34);
  localparam logic [CW-1:0] FN_SLT   = CW'(42);
  localparam logic [CW-1:0] FN_SLL   = CW'(0);
  localparam logic [CW-1:0] FN_MULTU = CW'(25);
  localparam logic [CW-1:0] FN_MFHI  = CW'(16);
  localparam logic [CW-1:0] FN_MFLO  = CW'(18);

  typedef enum logic {IDLE, MUL_WAIT} stateT;

  stateT            state, stateNext;
  logic [31:0]      hi, hiNext;
  logic [31:0]      lo, loNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [31:0]      dataReg, dataNext;
  logic             outValidReg, outValidNext;
  logic             errOpReg, errOpNext;
  logic             readyReg, readyNext;

  // State and registered outputs; reset dominates every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      dataReg     <= '0;
      outValidReg <= 1'b0;
      errOpReg    <= 1'b0;
      readyReg    <= 1'b1;
    end else begin
      state       <= stateNext;
      hi          <= hiNext;
      lo          <= loNext;
      cnt         <= cntNext;
      dataReg     <= dataNext;
      outValidReg <= outValidNext;
      errOpReg    <= errOpNext;
      readyReg    <= readyNext;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    stateNext    = state;
    hiNext       = hi;
    loNext       = lo;
    cntNext      = cnt;
    dataNext     = dataReg;
    outValidNext = 1'b0;
    errOpNext    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.inValid) begin
          case (bus.Signal)
            FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: begin
              dataNext     = bus.ALUOut;
              outValidNext = 1'b1;
            end
            FN_SLL: begin
              dataNext     = bus.ShifterOut;
              outValidNext = 1'b1;
            end
            FN_MFHI: begin
              dataNext     = hi;
              outValidNext = 1'b1;
            end
            FN_MFLO: begin
              dataNext     = lo;
              outValidNext = 1'b1;
            end
            FN_MULTU: begin
              stateNext = MUL_WAIT;
              cntNext   = '0;
            end
            default: begin
              dataNext     = '0;
              outValidNext = 1'b1;
              errOpNext    = 1'b1;
            end
          endcase
        end
      end
      MUL_WAIT: begin
        // An issue attempt while busy is dropped and flagged; the multiply carries on.
        errOpNext = bus.inValid;
        if (bus.MulDone) begin
          hiNext    = bus.MulProduct[63:32];
          loNext    = bus.MulProduct[31:0];
          stateNext = IDLE;
        end else if (cnt == CNT_LAST) begin
          stateNext = IDLE;
          errOpNext = 1'b1;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase

    readyNext = (stateNext == IDLE);
  end

  assign bus.dataOut  = dataReg;
  assign bus.outValid = outValidReg;
  assign bus.errOp    = errOpReg;
  assign bus.ready    = readyReg;

endmodule

// File: tb/tb_result_hilo_stage.sv
// Bench for result_hilo_stage: vector table, directed multiply scenarios and
// randomized traffic, all scored against a cycle-level behavioural model.
module tb_result_hilo_stage;

  localparam int unsigned MUL_TIMEOUT = 40;
  localparam int unsigned CW          = 6;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  // Model state: what the stage should show after the next edge.
  logic [31:0] eData;
  logic        eValid;
  logic        eErr;
  logic        eReady;
  logic [31:0] mHi;
  logic [31:0] mLo;
  bit          busy;
  int          waited;

  result_hilo_stage_if #(.CW(CW)) bus ();

  result_hilo_stage #(.MUL_TIMEOUT(MUL_TIMEOUT), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: one call per clock, using the inputs currently driven.
  task automatic modelStep();
    int c;
    c = int'(bus.Signal);
    if (reset) begin
      eData = '0; eValid = 1'b0; eErr = 1'b0;
      mHi = '0; mLo = '0; busy = 1'b0; waited = 0;
    end else if (!busy) begin
      eValid = 1'b0;
      eErr   = 1'b0;
      if (bus.inValid) begin
        if (c == 36 || c == 37 || c == 32 || c == 34 || c == 42) begin
          eData = bus.ALUOut; eValid = 1'b1;
        end else if (c == 0) begin
          eData = bus.ShifterOut; eValid = 1'b1;
        end else if (c == 16) begin
          eData = mHi; eValid = 1'b1;
        end else if (c == 18) begin
          eData = mLo; eValid = 1'b1;
        end else if (c == 25) begin
          busy = 1'b1; waited = 0;
        end else begin
          eData = '0; eValid = 1'b1; eErr = 1'b1;
        end
      end
    end else begin
      eValid = 1'b0;
      eErr   = bus.inValid;
      waited++;
      if (bus.MulDone) begin
        mHi  = bus.MulProduct[63:32];
        mLo  = bus.MulProduct[31:0];
        busy = 1'b0;
      end else if (waited == MUL_TIMEOUT) begin
        busy = 1'b0;
        eErr = 1'b1;
      end
    end
    eReady = !busy;
  endtask

  // Advance one clock and score every output against the model.
  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    check("dataOut",  64'(bus.dataOut),  64'(eData));
    check("outValid", 64'(bus.outValid), 64'(eValid));
    check("ready",    64'(bus.ready),    64'(eReady));
    check("errOp",    64'(bus.errOp),    64'(eErr));
  endtask

  task automatic setIn(input logic iv, input int code, input logic [31:0] alu,
                       input logic [31:0] sh, input logic md, input logic [63:0] prod);
    bus.inValid    = iv;
    bus.Signal     = CW'(code);
    bus.ALUOut     = alu;
    bus.ShifterOut = sh;
    bus.MulDone    = md;
    bus.MulProduct = prod;
  endtask

  task automatic idle();
    setIn(1'b0, 63, 32'h0, 32'h0, 1'b0, 64'h0);
  endtask

  typedef struct {
    int          code;
    logic        inValid;
    logic [31:0] alu;
    logic [31:0] sh;
    logic [31:0] expData;
    logic        expValid;
    logic        expErr;
  } vecT;

  vecT vecs[12];
  int  codes[9] = '{36, 37, 32, 34, 42, 0, 25, 16, 18};

  initial begin
    int lowCycles;
    int errCnt;
    total = 0;
    bad   = 0;
    eData = '0; eValid = 1'b0; eErr = 1'b0; eReady = 1'b1;
    mHi = '0; mLo = '0; busy = 1'b0; waited = 0;

    // Reset with a live issue and a MulDone in the same cycle.
    reset = 1'b1;
    setIn(1'b1, 32, 32'hAAAA_5555, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    tick();
    check("rst_data",  64'(bus.dataOut),  64'h0);
    check("rst_valid", 64'(bus.outValid), 64'h0);
    check("rst_ready", 64'(bus.ready),    64'h1);
    check("rst_err",   64'(bus.errOp),    64'h0);
    reset = 1'b0;
    idle();

    // Single-cycle operations from IDLE.
    vecs[0]  = '{32, 1'b1, 32'h0000_0005, 32'h0,         32'h0000_0005, 1'b1, 1'b0};
    vecs[1]  = '{0,  1'b1, 32'hDEAD_BEEF, 32'h0000_0080, 32'h0000_0080, 1'b1, 1'b0};
    vecs[2]  = '{36, 1'b1, 32'h0000_0F0F, 32'h1,         32'h0000_0F0F, 1'b1, 1'b0};
    vecs[3]  = '{32, 1'b0, 32'h0000_9999, 32'h2,         32'h0000_0F0F, 1'b0, 1'b0};
    vecs[4]  = '{37, 1'b1, 32'hFFFF_0000, 32'h3,         32'hFFFF_0000, 1'b1, 1'b0};
    vecs[5]  = '{34, 1'b1, 32'hFFFF_FFFF, 32'h4,         32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6]  = '{42, 1'b1, 32'h0000_0001, 32'h5,         32'h0000_0001, 1'b1, 1'b0};
    vecs[7]  = '{1,  1'b1, 32'h0000_0055, 32'h6,         32'h0000_0000, 1'b1, 1'b1};
    vecs[8]  = '{42, 1'b1, 32'h0000_0007, 32'h7,         32'h0000_0007, 1'b1, 1'b0};
    vecs[9]  = '{63, 1'b1, 32'h0000_0066, 32'h8,         32'h0000_0000, 1'b1, 1'b1};
    vecs[10] = '{16, 1'b1, 32'h0000_0077, 32'h9,         32'h0000_0000, 1'b1, 1'b0};
    vecs[11] = '{18, 1'b0, 32'h0000_0088, 32'hA,         32'h0000_0000, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      setIn(vecs[i].inValid, vecs[i].code, vecs[i].alu, vecs[i].sh, 1'b0, 64'h0);
      tick();
      check($sformatf("vec%0d_data", i),  64'(bus.dataOut),  64'(vecs[i].expData));
      check($sformatf("vec%0d_valid", i), 64'(bus.outValid), 64'(vecs[i].expValid));
      check($sformatf("vec%0d_err", i),   64'(bus.errOp),    64'(vecs[i].expErr));
      check($sformatf("vec%0d_ready", i), 64'(bus.ready),    64'h1);
    end

    // MulDone while IDLE must not touch HI/LO.
    setIn(1'b0, 63, 32'h0, 32'h0, 1'b1, 64'h1111_2222_3333_4444);
    tick();
    setIn(1'b1, 16, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    check("idle_done_hi", 64'(bus.dataOut), 64'h0);

    // MULTU completing after 33 cycles, then MFHI/MFLO back to back.
    setIn(1'b1, 25, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    check("mul_ready_low", 64'(bus.ready),    64'h0);
    check("mul_no_valid",  64'(bus.outValid), 64'h0);
    idle();
    for (int i = 0; i < 32; i++) tick();
    setIn(1'b0, 63, 32'h0, 32'h0, 1'b1, 64'h0000_0001_FFFF_FFFE);
    tick();
    check("mul_done_ready", 64'(bus.ready),    64'h1);
    check("mul_done_valid", 64'(bus.outValid), 64'h0);
    setIn(1'b1, 16, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    check("mfhi_after_mul", 64'(bus.dataOut), 64'h0000_0001);
    setIn(1'b1, 18, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    check("mflo_after_mul", 64'(bus.dataOut), 64'hFFFF_FFFE);

    // MULTU with no completion: timeout after MUL_TIMEOUT cycles.
    setIn(1'b1, 25, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    idle();
    lowCycles = (bus.ready == 1'b0) ? 1 : 0;
    errCnt    = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.errOp) errCnt++;
      if (bus.ready) break;
      lowCycles++;
    end
    check("timeout_low_cycles", 64'(lowCycles), 64'(MUL_TIMEOUT));
    check("timeout_err_pulses", 64'(errCnt), 64'h1);
    tick();
    check("timeout_err_single", 64'(bus.errOp), 64'h0);
    setIn(1'b1, 16, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    check("timeout_keeps_hi", 64'(bus.dataOut), 64'h0000_0001);

    // ADD issued while busy: dropped with errOp, multiply still completes.
    setIn(1'b1, 25, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    idle();
    tick();
    setIn(1'b1, 32, 32'h0000_1234, 32'h0, 1'b0, 64'h0);
    tick();
    check("busy_add_err",   64'(bus.errOp),    64'h1);
    check("busy_add_valid", 64'(bus.outValid), 64'h0);
    check("busy_add_ready", 64'(bus.ready),    64'h0);
    idle();
    tick();
    setIn(1'b0, 63, 32'h0, 32'h0, 1'b1, 64'hCAFE_F00D_0BAD_BEEF);
    tick();
    check("busy_add_done", 64'(bus.ready), 64'h1);
    setIn(1'b1, 18, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    check("busy_add_lo", 64'(bus.dataOut), 64'h0BAD_BEEF);

    // MulDone on the very cycle the timeout would fire: completion wins.
    setIn(1'b1, 25, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    idle();
    for (int i = 0; i < int'(MUL_TIMEOUT) - 1; i++) tick();
    check("edge_still_busy", 64'(bus.ready), 64'h0);
    setIn(1'b0, 63, 32'h0, 32'h0, 1'b1, 64'h0102_0304_0506_0708);
    tick();
    check("edge_done_no_err", 64'(bus.errOp), 64'h0);
    check("edge_done_ready",  64'(bus.ready), 64'h1);
    setIn(1'b1, 16, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    check("edge_done_hi", 64'(bus.dataOut), 64'h0102_0304);

    // Reset mid-multiply; a later MulDone is ignored.
    setIn(1'b1, 25, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    idle();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    setIn(1'b0, 63, 32'h0, 32'h0, 1'b1, 64'h1234_5678_9ABC_DEF0);
    tick();
    check("rst_mul_ready", 64'(bus.ready), 64'h1);
    setIn(1'b1, 18, 32'h0, 32'h0, 1'b0, 64'h0);
    tick();
    check("rst_mul_lo", 64'(bus.dataOut), 64'h0);
    setIn(1'b1, 16, 32'hFFFF_FFFF, 32'h0, 1'b0, 64'h0);
    tick();
    check("rst_mul_hi", 64'(bus.dataOut), 64'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int code;
      if ($urandom_range(0, 99) < 85) code = codes[$urandom_range(0, 8)];
      else code = int'($urandom_range(0, 63));
      setIn(($urandom_range(0, 99) < 40), code, $urandom, $urandom,
            ($urandom_range(0, 29) == 0), {$urandom, $urandom});
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
